// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and defaults.
// Imported by the arbiter top and its round-robin selector.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    localparam int unsigned START_TIMEOUT_DEFAULT = 16;
    localparam int unsigned GID_W                 = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Stateless round-robin selector: the first active request after the last grant wins.
// Any request at the last-granted index is considered only after all others.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [GID_W-1:0] last_i,
    output logic [GID_W-1:0] gnt_o,
    output logic             any_o
);

    logic [NREQ-1:0] rot;
    int unsigned     idx;

    always_comb begin
        gnt_o = last_i;
        any_o = 1'b0;
        rot   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_i) + k) % NREQ;
            rot = req_i >> idx;
            if (!any_o && rot[0]) begin
                any_o = 1'b1;
                gnt_o = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto a single uart_send transmitter with
// round-robin fairness and a start-timeout watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    output logic [NREQ-1:0]     REQ_READY,
    output logic [7:0]          TX_DATA,
    output logic                TX_DATA_READY,
    input  logic                TX_IDLE,
    output logic [GID_W-1:0]    GRANT_ID,
    output logic                TIMEOUT_ERR
);

    localparam int unsigned    CW       = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(START_TIMEOUT - 1);

    state_t             state_q;
    logic [NREQ-1:0]    ready_q;
    logic [7:0]         data_q;
    logic               txdr_q;
    logic [GID_W-1:0]   gid_q;
    logic               err_q;
    logic [CW-1:0]      cnt_q;
    logic               armed_q;

    logic [GID_W-1:0]   gnt;
    logic               any_gnt;
    logic [NREQ-1:0]    ready_d;
    logic [7:0]         data_d;
    logic [8*NREQ-1:0]  data_shift;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i  (REQ_VALID),
        .last_i (gid_q),
        .gnt_o  (gnt),
        .any_o  (any_gnt)
    );

    always_comb begin
        data_shift = REQ_DATA >> {gnt, 3'b000};
        data_d     = data_shift[7:0];
        ready_d    = NREQ'(1) << gnt;
    end

    // armed_q keeps the first cycle after reset release free of any grant.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ready_q <= '0;
            data_q  <= '0;
            txdr_q  <= 1'b0;
            gid_q   <= GID_W'(NREQ - 1);
            err_q   <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            ready_q <= '0;
            txdr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (armed_q && TX_IDLE && any_gnt) begin
                        ready_q <= ready_d;
                        data_q  <= data_d;
                        gid_q   <= gnt;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    txdr_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (!TX_IDLE) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (TX_IDLE) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign REQ_READY     = ready_q;
    assign TX_DATA       = data_q;
    assign TX_DATA_READY = txdr_q;
    assign GRANT_ID      = gid_q;
    assign TIMEOUT_ERR   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic [NREQ-1:0]     REQ_VALID = '0;
    logic [8*NREQ-1:0]   REQ_DATA  = '0;
    logic [NREQ-1:0]     REQ_READY;
    logic [7:0]          TX_DATA;
    logic                TX_DATA_READY;
    logic                TX_IDLE;
    logic [2:0]          GRANT_ID;
    logic                TIMEOUT_ERR;

    int   busy_cnt     = 0;
    logic force_busy   = 1'b0;
    logic uart_respond = 1'b1;
    logic [7:0] txlog[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign TX_IDLE = !force_busy && (busy_cnt == 0);

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .START_TIMEOUT (TMO)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_DATA      (REQ_DATA),
        .REQ_READY     (REQ_READY),
        .TX_DATA       (TX_DATA),
        .TX_DATA_READY (TX_DATA_READY),
        .TX_IDLE       (TX_IDLE),
        .GRANT_ID      (GRANT_ID),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // uart_send model: IDLE low for 10 cycles after each accepted pulse
    always @(posedge CLK) begin
        if (TX_DATA_READY) begin
            txlog.push_back(TX_DATA);
            if (uart_respond) busy_cnt <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Requesters: FIFO per index, valid while non-empty and not withdrawn
    logic [7:0]      rbuf[NREQ][8];
    logic [2:0]      rhead[NREQ];
    int              rcnt[NREQ];
    logic [NREQ-1:0] rmask    = '1;
    logic [NREQ-1:0] pop_pend = '0;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = '0;
            rcnt[i]  = 0;
        end
    end

    task automatic push(input int i, input logic [7:0] b);
        rbuf[i][3'(rhead[i] + 3'(rcnt[i]))] = b;
        rcnt[i]++;
    endtask

    // Priority distance from the last grant: the next index is 0, the last one NREQ-1
    function automatic int pick(logic [NREQ-1:0] v, int last);
        int best  = -1;
        int bestd = NREQ + 1;
        for (int j = 0; j < NREQ; j++) begin
            int d;
            d = (j - last - 1 + 2 * NREQ) % NREQ;
            if (v[j] && d < bestd) begin
                bestd = d;
                best  = j;
            end
        end
        return best;
    endfunction

    logic [NREQ-1:0] e_ready = '0;
    logic            e_txdr  = 1'b0;
    logic [7:0]      e_txdata = '0;
    logic [2:0]      e_gid   = 3'(NREQ - 1);
    logic            e_err   = 1'b0;
    int   m_last = NREQ - 1;
    bit   m_free = 0, m_arm = 0, m_wait_start = 0, m_wait_done = 0;
    int   m_cnt  = 0;

    always @(negedge CLK) begin
        logic [NREQ-1:0] n_ready, pops;
        logic            n_txdr, n_err;
        logic [7:0]      n_data;
        logic [2:0]      n_gid;
        int              g;

        if (!RST) begin
            e_ready  = '0;
            e_txdr   = 1'b0;
            e_txdata = '0;
            e_gid    = 3'(NREQ - 1);
            e_err    = 1'b0;
        end
        check("REQ_READY",     32'(REQ_READY),     32'(e_ready));
        check("TX_DATA_READY", 32'(TX_DATA_READY), 32'(e_txdr));
        check("TX_DATA",       32'(TX_DATA),       32'(e_txdata));
        check("GRANT_ID",      32'(GRANT_ID),      32'(e_gid));
        check("TIMEOUT_ERR",   32'(TIMEOUT_ERR),   32'(e_err));

        pops     = pop_pend;
        pop_pend = REQ_READY & REQ_VALID;
        for (int i = 0; i < NREQ; i++) begin
            if (pops[i]) begin
                rhead[i] = rhead[i] + 3'd1;
                rcnt[i]--;
            end
            REQ_VALID[i]       = rmask[i] && (rcnt[i] > 0);
            REQ_DATA[8*i +: 8] = rbuf[i][rhead[i]];
        end

        if (!RST) begin
            m_last = NREQ - 1;
            m_free = 0;
            m_arm  = 1;
            m_wait_start = 0;
            m_wait_done  = 0;
            m_cnt  = 0;
        end else begin
            n_ready = '0;
            n_txdr  = 1'b0;
            n_data  = e_txdata;
            n_gid   = e_gid;
            n_err   = e_err;
            if (m_free && TX_IDLE && (REQ_VALID != '0)) begin
                g = pick(REQ_VALID, m_last);
                n_ready[g] = 1'b1;
                n_gid      = 3'(g);
                n_data     = REQ_DATA[8*g +: 8];
                m_last     = g;
                m_free     = 0;
            end
            if (m_arm) begin
                m_arm  = 0;
                m_free = 1;
            end
            if (e_ready != '0) n_txdr = 1'b1;
            if (m_wait_done && TX_IDLE) begin
                m_wait_done = 0;
                m_free      = 1;
            end
            if (e_txdr) begin
                m_wait_start = 1;
                m_cnt        = 0;
            end
            if (m_wait_start) begin
                if (!TX_IDLE) begin
                    m_wait_start = 0;
                    m_wait_done  = 1;
                end else begin
                    m_cnt++;
                    if (m_cnt == TMO) begin
                        m_wait_start = 0;
                        n_err        = 1'b1;
                        m_free       = 1;
                    end
                end
            end
            e_ready  = n_ready;
            e_txdr   = n_txdr;
            e_txdata = n_data;
            e_gid    = n_gid;
            e_err    = n_err;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset(input int n);
        tick();
        RST = 1'b0;
        repeat (n) tick();
        RST = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (REQ_READY != '0) break;
        end
        check({tag, "_ready_seen"}, 32'(REQ_READY != '0), 32'd1);
    endtask

    task automatic wait_log(input int n, input string tag);
        for (int k = 0; k < 300 && txlog.size() < n; k++) tick();
        check({tag, "_log_size"}, 32'(txlog.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] exp2[5];
        logic [7:0] exp3[3];
        int n;

        exp2 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp3 = '{8'hA0, 8'hA1, 8'hA2};

        // Reset state and first grant
        do_reset(3);
        check("rst_gid", 32'(GRANT_ID), 32'd3);
        check("rst_err", 32'(TIMEOUT_ERR), 32'd0);
        push(0, 8'h41);
        wait_ready("t1");
        check("t1_ready_vec", 32'(REQ_READY), 32'h1);
        check("t1_gid", 32'(GRANT_ID), 32'd0);
        @(negedge CLK);
        check("t1_pulse", 32'(TX_DATA_READY), 32'd1);
        check("t1_data", 32'(TX_DATA), 32'h41);
        repeat (15) tick();

        // All four requesters active: rotation and wrap
        do_reset(2);
        txlog.delete();
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
        wait_log(5, "t2");
        for (int i = 0; i < 5; i++)
            if (i < txlog.size()) check("t2_order", 32'(txlog[i]), 32'(exp2[i]));
        repeat (15) tick();

        // Single requester served back-to-back, two cycles from IDLE rise to READY
        txlog.delete();
        push(2, 8'hA0); push(2, 8'hA1); push(2, 8'hA2);
        wait_ready("t3a");
        check("t3_ready_vec", 32'(REQ_READY), 32'h4);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 40 && TX_IDLE; k++) @(negedge CLK);
            for (int k = 0; k < 40 && !TX_IDLE; k++) @(negedge CLK);
            n = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge CLK);
                n++;
                if (REQ_READY != '0) break;
            end
            check("t3_rise_to_ready", 32'(n), 32'd2);
            check("t3_ready_vec_n", 32'(REQ_READY), 32'h4);
        end
        wait_log(3, "t3");
        for (int i = 0; i < 3; i++)
            if (i < txlog.size()) check("t3_order", 32'(txlog[i]), 32'(exp3[i]));
        repeat (15) tick();

        // Transmitter never starts: timeout 16 cycles after the pulse
        uart_respond = 1'b0;
        push(1, 8'h55);
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (TX_DATA_READY) break;
        end
        check("t4_pulse_seen", 32'(TX_DATA_READY), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            n++;
            if (TIMEOUT_ERR) break;
        end
        check("t4_timeout_delay", 32'(n), 32'd16);
        tick();
        uart_respond = 1'b1;
        push(3, 8'h66);
        wait_ready("t4");
        check("t4_ready_vec", 32'(REQ_READY), 32'h8);
        check("t4_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
        repeat (15) tick();

        // Reset while waiting for the transmitter to finish
        push(0, 8'h77);
        wait_ready("t5a");
        for (int k = 0; k < 40 && TX_IDLE; k++) @(negedge CLK);
        tick(); tick();
        push(0, 8'h88); push(1, 8'h99);
        tick();
        RST = 1'b0;
        #1;
        check("t5_rst_ready", 32'(REQ_READY), 32'd0);
        check("t5_rst_pulse", 32'(TX_DATA_READY), 32'd0);
        check("t5_rst_data", 32'(TX_DATA), 32'h00);
        check("t5_rst_gid", 32'(GRANT_ID), 32'd3);
        check("t5_rst_err", 32'(TIMEOUT_ERR), 32'd0);
        tick(); tick();
        RST = 1'b1;
        wait_ready("t5b");
        check("t5_ready_vec", 32'(REQ_READY), 32'h1);
        @(negedge CLK);
        check("t5_data", 32'(TX_DATA), 32'h88);
        repeat (30) tick();

        // Externally busy transmitter blocks grants
        force_busy = 1'b1;
        push(1, 8'h5A);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (REQ_READY != '0) n++;
        end
        check("t6_no_grant_busy", 32'(n), 32'd0);
        tick();
        force_busy = 1'b0;
        wait_ready("t6");
        check("t6_ready_vec", 32'(REQ_READY), 32'h2);
        repeat (15) tick();

        // Withdrawn requester skipped, then served after wrap
        force_busy = 1'b1;
        push(2, 8'hB2); push(3, 8'hB3);
        repeat (3) tick();
        rmask[2] = 1'b0;
        repeat (2) tick();
        force_busy = 1'b0;
        wait_ready("t7a");
        check("t7_skip_vec", 32'(REQ_READY), 32'h8);
        repeat (15) tick();
        rmask[2] = 1'b1;
        wait_ready("t7b");
        check("t7_wrap_vec", 32'(REQ_READY), 32'h4);
        repeat (15) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of byte requesters (2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 16: cycles to wait for the transmitter to leave idle after a send pulse.
REQ-003 SHALL have port CLK, input, 1: the single system clock; all logic on posedge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port REQ_VALID, input, NREQ: per-requester byte-available flag.
REQ-006 SHALL have port REQ_DATA, input, 8*NREQ: per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port REQ_READY, output, NREQ: one-cycle accept strobe per requester.
REQ-008 SHALL have port TX_DATA, output, 8: byte to the uart_send DATA input.
REQ-009 SHALL have port TX_DATA_READY, output, 1: one-cycle send pulse to uart_send DATA_READY.
REQ-010 SHALL have port TX_IDLE, input, 1: uart_send IDLE status.
REQ-011 SHALL have port GRANT_ID, output, 3: index of the requester last accepted.
REQ-012 SHALL have port TIMEOUT_ERR, output, 1: sticky flag set when the transmitter fails to start.

Function
REQ-013 SHALL implement FSM states S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE.
REQ-014 In S_IDLE with TX_IDLE=1 and any REQ_VALID bit set, SHALL grant round-robin starting at (last grant+1) mod NREQ.
REQ-015 On grant, SHALL pulse REQ_READY[g] for exactly one cycle, latch REQ_DATA[g] into TX_DATA, set GRANT_ID=g, and go to S_ISSUE.
REQ-016 Handshake: a byte transfers only in the cycle where REQ_VALID[i]=1 and REQ_READY[i]=1; the requester holds data and valid until then.
REQ-017 In S_ISSUE, SHALL assert TX_DATA_READY for one cycle and go to S_WAIT_START; TX_DATA SHALL stay stable from S_ISSUE until S_IDLE is re-entered.
REQ-018 Grant-to-pulse latency SHALL be exactly 1 cycle, giving a REQ_READY-to-TX_DATA_READY distance of 1 clock.
REQ-019 In S_WAIT_START, TX_IDLE=0 SHALL move to S_WAIT_DONE; after START_TIMEOUT cycles with TX_IDLE=1, SHALL set TIMEOUT_ERR and return to S_IDLE (byte dropped).
REQ-020 In S_WAIT_DONE, TX_IDLE=1 SHALL return to S_IDLE; a new grant is allowed no earlier than the following cycle.
REQ-021 SHALL not grant while TX_IDLE=0 in S_IDLE (an externally busy transmitter is honoured).
REQ-022 Requesters whose REQ_VALID deasserts before grant SHALL be skipped without penalty.
REQ-023 Round-robin pointer SHALL wrap from NREQ-1 to 0; a single active requester SHALL be served back-to-back.
REQ-024 At most one REQ_READY bit SHALL be high in any cycle.
REQ-025 TIMEOUT_ERR SHALL stay set until reset.

Reset
REQ-026 RST low SHALL asynchronously force: state S_IDLE, REQ_READY=0, TX_DATA_READY=0, TX_DATA=8'h00, GRANT_ID=NREQ-1 (so requester 0 wins first), TIMEOUT_ERR=0, timeout counter=0.
REQ-027 Reset asserted mid-transfer SHALL abandon the byte; no REQ_READY or TX_DATA_READY pulse SHALL be produced while RST is low or in the first cycle after release.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit) and the START_TIMEOUT default.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last grant; outputs: grant index, any-grant flag), combinational with no state.
REQ-030 The FSM, data latch and timeout counter ($clog2(START_TIMEOUT+1) bits) SHALL live in uart_tx_arbiter.

Verification (uart_send model with IDLE low 10 cycles after each pulse)
REQ-031 After reset, REQ_VALID=4'b0001 with byte 8'h41 -> REQ_READY[0] pulse; TX_DATA_READY one cycle later with TX_DATA=8'h41; GRANT_ID=0.
REQ-032 REQ_VALID=4'b1111 held, bytes 8'h10..8'h13 -> transmitted order 10,11,12,13,10 and no overlap with IDLE=0.
REQ-033 Only requester 2 valid, three bytes 8'hA0,A1,A2 -> served back-to-back, each grant the cycle after TX_IDLE rises.
REQ-034 Model never drops IDLE after the pulse -> TIMEOUT_ERR=1 exactly 16 cycles later; FSM back in S_IDLE; next request served.
REQ-035 RST driven low during S_WAIT_DONE -> all outputs at reset values immediately; after release, requester 0 has priority.
REQ-036 TX_IDLE held 0 externally with REQ_VALID=4'b0010 -> no REQ_READY until TX_IDLE=1.
